// File: rtl/board_io_ctrl.sv
// Board I/O conditioner: SoC reset sequencing from PLL lock, switch/button
// synchronise + debounce, and LED drive with global PWM dimming.
//
// state     | meaning
// WAIT_LOCK | SoC held in reset, waiting for synchronised PLL lock
// HOLD      | lock seen, counting RST_HOLD_CYCLES before releasing SoC
// RUN       | SoC released; loss of lock returns to WAIT_LOCK
module board_io_ctrl #(
    parameter int NUM_SW          = 16,
    parameter int NUM_BTN         = 1,
    parameter int NUM_LED         = 16,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 800000,
    parameter int RST_HOLD_CYCLES = 1024,
    parameter int PWM_W           = 8
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               pll_locked_i,
    input  logic [NUM_SW-1:0]  sw_i,
    input  logic [NUM_BTN-1:0] btn_i,
    input  logic [NUM_LED-1:0] led_i,
    input  logic [PWM_W-1:0]   led_brightness_i,
    output logic               soc_rst_o,
    output logic [NUM_SW-1:0]  sw_o,
    output logic [NUM_BTN-1:0] btn_level_o,
    output logic [NUM_BTN-1:0] btn_press_o,
    output logic [NUM_LED-1:0] led_o
);

    localparam int NCH = NUM_SW + NUM_BTN;
    localparam int DCW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int HCW = $clog2(RST_HOLD_CYCLES + 1);
    localparam logic [DCW-1:0] DB_LAST   = DCW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HCW-1:0] HOLD_LAST = HCW'(RST_HOLD_CYCLES - 1);

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        HOLD      = 2'd1,
        RUN       = 2'd2
    } state_t;

    logic [SYNC_STAGES-1:0] lock_sync;
    logic [NCH-1:0]         in_sync [SYNC_STAGES];
    logic                   lock_s;
    logic [NCH-1:0]         synced;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            lock_sync <= '0;
            for (int s = 0; s < SYNC_STAGES; s++) in_sync[s] <= '0;
        end else begin
            lock_sync  <= {lock_sync[SYNC_STAGES-2:0], pll_locked_i};
            in_sync[0] <= {btn_i, sw_i};
            for (int s = 1; s < SYNC_STAGES; s++) in_sync[s] <= in_sync[s-1];
        end
    end

    assign lock_s = lock_sync[SYNC_STAGES-1];
    assign synced = in_sync[SYNC_STAGES-1];

    // Switches occupy the low channels, buttons the high ones.
    logic [NCH-1:0] stable;
    logic [NCH-1:0] accept;
    logic [DCW-1:0] db_cnt [NCH];

    always_comb begin
        accept = '0;
        for (int i = 0; i < NCH; i++)
            accept[i] = (synced[i] != stable[i]) && (db_cnt[i] == DB_LAST);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stable      <= '0;
            btn_press_o <= '0;
            for (int i = 0; i < NCH; i++) db_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (synced[i] == stable[i]) begin
                    db_cnt[i] <= '0;
                end else if (accept[i]) begin
                    stable[i] <= synced[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + DCW'(1);
                end
            end
            btn_press_o <= accept[NCH-1:NUM_SW] & synced[NCH-1:NUM_SW];
        end
    end

    assign sw_o        = stable[NUM_SW-1:0];
    assign btn_level_o = stable[NCH-1:NUM_SW];

    state_t         state_q, state_d;
    logic [HCW-1:0] hold_q, hold_d;

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        case (state_q)
            WAIT_LOCK: begin
                if (lock_s) begin
                    state_d = HOLD;
                    hold_d  = '0;
                end
            end
            HOLD: begin
                if (!lock_s)
                    state_d = WAIT_LOCK;
                else if (hold_q == HOLD_LAST)
                    state_d = RUN;
                else
                    hold_d = hold_q + HCW'(1);
            end
            RUN: begin
                if (!lock_s) state_d = WAIT_LOCK;
            end
            default: state_d = WAIT_LOCK;
        endcase
    end

    // soc_rst_o follows the registered state, so it lags state entry by one edge.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= WAIT_LOCK;
            hold_q    <= '0;
            soc_rst_o <= 1'b1;
        end else begin
            state_q   <= state_d;
            hold_q    <= hold_d;
            soc_rst_o <= (state_q != RUN);
        end
    end

    logic [PWM_W-1:0] pwm_cnt;
    logic             pwm_on;

    assign pwm_on = (&led_brightness_i) | (pwm_cnt < led_brightness_i);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pwm_cnt <= '0;
            led_o   <= '0;
        end else begin
            pwm_cnt <= pwm_cnt + PWM_W'(1);
            led_o   <= led_i & {NUM_LED{pwm_on & ~soc_rst_o}};
        end
    end

endmodule

// File: tb/tb_board_io_ctrl.sv
// Directed bench for board_io_ctrl with small parameters: reset sequencing,
// lock loss, button/switch debounce, PWM duty and mid-sequence reset.
module tb_board_io_ctrl;

    localparam int NUM_SW  = 4;
    localparam int NUM_BTN = 1;
    localparam int NUM_LED = 4;
    localparam int PWM_W   = 4;

    logic               clk_i = 1'b0;
    logic               rst_i;
    logic               pll_locked_i;
    logic [NUM_SW-1:0]  sw_i;
    logic [NUM_BTN-1:0] btn_i;
    logic [NUM_LED-1:0] led_i;
    logic [PWM_W-1:0]   led_brightness_i;
    logic               soc_rst_o;
    logic [NUM_SW-1:0]  sw_o;
    logic [NUM_BTN-1:0] btn_level_o;
    logic [NUM_BTN-1:0] btn_press_o;
    logic [NUM_LED-1:0] led_o;

    int n_checks = 0;
    int n_errors = 0;

    board_io_ctrl #(
        .NUM_SW(NUM_SW), .NUM_BTN(NUM_BTN), .NUM_LED(NUM_LED),
        .SYNC_STAGES(2), .DEBOUNCE_CYCLES(8), .RST_HOLD_CYCLES(16), .PWM_W(PWM_W)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i), .pll_locked_i(pll_locked_i),
        .sw_i(sw_i), .btn_i(btn_i), .led_i(led_i),
        .led_brightness_i(led_brightness_i), .soc_rst_o(soc_rst_o),
        .sw_o(sw_o), .btn_level_o(btn_level_o), .btn_press_o(btn_press_o),
        .led_o(led_o)
    );

    always #5 clk_i = ~clk_i;

    // Inputs driven after this return are sampled at the next rising edge.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    int on_cnt;
    int bad_cnt;
    int press_cnt;
    int sw_chg;
    logic [NUM_SW-1:0] sw_prev;
    logic [PWM_W-1:0]  bri_tab [3];
    int                duty_tab [3];

    initial begin
        bri_tab[0] = 4'd0;  duty_tab[0] = 0;
        bri_tab[1] = 4'd5;  duty_tab[1] = 5;
        bri_tab[2] = 4'd15; duty_tab[2] = 16;

        rst_i = 1'b1; pll_locked_i = 1'b1; sw_i = '1; btn_i = '1;
        led_i = '1; led_brightness_i = '1;
        repeat (3) tick();
        chk("rst_soc", soc_rst_o, 1);
        chk("rst_sw", sw_o, 0);
        chk("rst_btn_level", btn_level_o, 0);
        chk("rst_btn_press", btn_press_o, 0);
        chk("rst_led", led_o, 0);

        // Lock already high at release: edge 0 is the first sampling edge.
        sw_i = '0; btn_i = '0; rst_i = 1'b0;
        for (int e = 0; e <= 20; e++) begin
            tick();
            if (e == 10) chk("hold_mid_soc", soc_rst_o, 1);
            if (e == 18) begin
                chk("hold_end_soc", soc_rst_o, 1);
                chk("led_off_in_reset", led_o, 0);
            end
            if (e == 19) chk("soc_release", soc_rst_o, 0);
            if (e == 20) chk("led_full_on", led_o, 4'hF);
        end

        for (int k = 0; k < 3; k++) begin
            led_brightness_i = bri_tab[k];
            tick(); tick();
            on_cnt = 0; bad_cnt = 0;
            for (int c = 0; c < 16; c++) begin
                tick();
                if (led_o == 4'hF) on_cnt++;
                else if (led_o != 4'h0) bad_cnt++;
            end
            chk($sformatf("pwm_duty_b%0d", bri_tab[k]), on_cnt, duty_tab[k]);
            chk("pwm_all_lanes", bad_cnt, 0);
        end
        led_i = 4'b1010; led_brightness_i = '1;
        tick(); tick();
        chk("led_mask", led_o, 4'b1010);
        chk("run_soc", soc_rst_o, 0);

        // One-cycle lock drop.
        pll_locked_i = 1'b0;
        tick();
        pll_locked_i = 1'b1;
        for (int e = 1; e <= 20; e++) begin
            tick();
            if (e == 2)  chk("drop_soc_still_low", soc_rst_o, 0);
            if (e == 3)  chk("drop_soc_rise", soc_rst_o, 1);
            if (e == 19) chk("relock_hold_end", soc_rst_o, 1);
            if (e == 20) chk("relock_release", soc_rst_o, 0);
        end

        // 7-cycle glitch must be discarded.
        btn_i = 1'b1;
        repeat (7) tick();
        btn_i = 1'b0;
        bad_cnt = 0;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (btn_level_o != 0 || btn_press_o != 0) bad_cnt++;
        end
        chk("btn_glitch_ignored", bad_cnt, 0);

        // 8-cycle press is accepted at edge 9.
        btn_i = 1'b1;
        for (int e = 0; e <= 10; e++) begin
            if (e == 8) btn_i = 1'b0;
            tick();
            if (e == 8) chk("btn_level_before", btn_level_o, 0);
            if (e == 9) begin
                chk("btn_level_accept", btn_level_o, 1);
                chk("btn_press_pulse", btn_press_o, 1);
            end
            if (e == 10) begin
                chk("btn_press_one_cycle", btn_press_o, 0);
                chk("btn_level_held", btn_level_o, 1);
            end
        end
        press_cnt = 0;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (btn_press_o != 0) press_cnt++;
        end
        chk("btn_no_release_pulse", press_cnt, 0);
        chk("btn_level_released", btn_level_o, 0);

        // Switch chatter every 3 cycles, then settle high.
        sw_chg = 0;
        for (int i = 0; i < 100; i++) begin
            sw_i = (((i / 3) % 2) == 0) ? 4'b0111 : 4'b0000;
            tick();
            if (sw_o != 0) sw_chg++;
        end
        sw_i = 4'b0111;
        sw_prev = sw_o;
        for (int e = 0; e <= 19; e++) begin
            tick();
            if (sw_o != sw_prev) sw_chg++;
            sw_prev = sw_o;
            if (e == 8) chk("sw_before_settle", sw_o, 0);
            if (e == 9) chk("sw_settled", sw_o, 4'b0111);
        end
        chk("sw_single_transition", sw_chg, 1);

        // Reset mid-HOLD with a button debounce in flight.
        pll_locked_i = 1'b0;
        repeat (4) tick();
        pll_locked_i = 1'b1; btn_i = 1'b1;
        repeat (8) tick();
        rst_i = 1'b1;
        tick();
        chk("midrst_soc", soc_rst_o, 1);
        chk("midrst_sw", sw_o, 0);
        chk("midrst_btn_level", btn_level_o, 0);
        chk("midrst_btn_press", btn_press_o, 0);
        chk("midrst_led", led_o, 0);
        rst_i = 1'b0;
        for (int e = 0; e <= 19; e++) begin
            tick();
            if (e == 8) chk("restart_btn_before", btn_level_o, 0);
            if (e == 9) begin
                chk("restart_btn_level", btn_level_o, 1);
                chk("restart_btn_press", btn_press_o, 1);
                chk("restart_sw", sw_o, 4'b0111);
            end
            if (e == 18) chk("restart_hold_end", soc_rst_o, 1);
            if (e == 19) chk("restart_release", soc_rst_o, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
